alu_arbiter_9bit: RTL and testbench

ALU_ARBITER_9BIT -- requirements
Module: alu_arbiter_9bit

---
 rtl/alu_arbiter_9bit.sv | 109 ++++++++++
 tb/tb_alu_arbiter_9bit.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_9bit.sv
// Round-robin arbiter that time-shares one combinational 9-bit add/sub ALU
// among NUM_REQ requesters, with one operation in flight at a time.
module alu_arbiter_9bit #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_select,
    input  logic [9*NUM_REQ-1:0]   req_a,
    input  logic [9*NUM_REQ-1:0]   req_b,
    output logic                   alu_select,
    output logic [8:0]             alu_a,
    output logic [8:0]             alu_b,
    input  logic [8:0]             alu_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [8:0]             resp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] next_ptr;
    logic            found;
    logic            lat_select;
    logic [8:0]      lat_a;
    logic [8:0]      lat_b;
    logic [ID_W-1:0] lat_id;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset && found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign alu_select = lat_select;
    assign alu_a      = lat_a;
    assign alu_b      = lat_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lat_select <= 1'b0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_id     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A grant here is always a transfer: ready tracks found.
                    if (found) begin
                        lat_select <= req_select[grant];
                        lat_a      <= req_a[9*grant +: 9];
                        lat_b      <= req_b[9*grant +: 9];
                        lat_id     <= grant;
                        rr_ptr     <= next_ptr;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data  <= alu_out;
                    resp_id    <= lat_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter_9bit.sv
// Directed self-checking bench for alu_arbiter_9bit with a behavioural
// 9-bit add/sub ALU attached to the shared datapath port.
module tb_alu_arbiter_9bit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_select;
    logic [35:0] req_a;
    logic [35:0] req_b;
    logic        alu_select;
    logic [8:0]  alu_a;
    logic [8:0]  alu_b;
    logic [8:0]  alu_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [8:0]  resp_data;

    int checks   = 0;
    int failures = 0;

    alu_arbiter_9bit #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_select (req_select),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_select (alu_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    assign alu_out = alu_select ? (alu_a - alu_b) : (alu_a + alu_b);

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic sel, input logic [8:0] a, input logic [8:0] b);
        req_select[idx]  = sel;
        req_a[9*idx +: 9] = a;
        req_b[9*idx +: 9] = b;
    endtask

    // Drives one operation from requester idx to completion and returns what came back.
    task automatic run_op(input int idx, input logic sel, input logic [8:0] a, input logic [8:0] b,
                          output logic [8:0] d, output logic [1:0] id, output bit timeout);
        int n;
        timeout = 1'b0;
        set_req(idx, sel, a, b);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        resp_ready     = 1'b1;
        #1;
        n = 0;
        while (!req_ready[idx] && n < 8) begin
            tick();
            n++;
        end
        if (!req_ready[idx]) timeout = 1'b1;
        tick();
        req_valid = '0;
        n = 0;
        while (!resp_valid && n < 8) begin
            tick();
            n++;
        end
        if (!resp_valid) timeout = 1'b1;
        d  = resp_data;
        id = resp_id;
        tick();
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready_comb: got %b expected 0000", req_ready);
        end
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 9'd0 || resp_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_resp: got valid=%b data=%0d id=%0d expected 0/0/0", resp_valid, resp_data, resp_id);
        end
        checks++;
        if (alu_a !== 9'd0 || alu_b !== 9'd0 || alu_select !== 1'b0) begin
            failures++;
            $display("FAIL reset_alu: got sel=%b a=%0d b=%0d expected 0/0/0", alu_select, alu_a, alu_b);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready_held: got %b expected 0000", req_ready);
        end
        reset     = 1'b0;
        req_valid = '0;
        tick();
    endtask

    task automatic test_single_op;
        set_req(0, 1'b0, 9'd100, 9'd27);
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || alu_a !== 9'd100 || alu_b !== 9'd27 || alu_select !== 1'b0) begin
            failures++;
            $display("FAIL single_exec: got ready=%b a=%0d b=%0d sel=%b expected 0000/100/27/0",
                     req_ready, alu_a, alu_b, alu_select);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 9'd127 || resp_id !== 2'd0) begin
            failures++;
            $display("FAIL single_resp: got valid=%b data=%0d id=%0d expected 1/127/0", resp_valid, resp_data, resp_id);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_one_cycle: got valid=%b expected 0", resp_valid);
        end
    endtask

    task automatic test_wrap;
        logic [8:0] d;
        logic [1:0] id;
        bit         to;
        run_op(0, 1'b0, 9'd500, 9'd20, d, id, to);
        checks++;
        if (to || d !== 9'd8 || id !== 2'd0) begin
            failures++;
            $display("FAIL wrap_add: got data=%0d id=%0d timeout=%0d expected 8/0/0", d, id, to);
        end
        run_op(0, 1'b1, 9'd5, 9'd10, d, id, to);
        checks++;
        if (to || d !== 9'd507 || id !== 2'd0) begin
            failures++;
            $display("FAIL wrap_sub: got data=%0d id=%0d timeout=%0d expected 507/0/0", d, id, to);
        end
    endtask

    task automatic test_round_robin;
        logic [8:0] exp_data [4];
        int         cnt [4];
        logic [3:0] onehot;
        int         n;
        int         e;
        exp_data = '{9'd1, 9'd10, 9'd23, 9'd28};
        cnt      = '{0, 0, 0, 0};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, i[0], 9'(10*i + 1), 9'(i));
        end
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        #1;
        for (int op = 0; op < 12; op++) begin
            e = op % 4;
            n = 0;
            while (req_ready === 4'b0000 && n < 8) begin
                tick();
                n++;
            end
            onehot    = '0;
            onehot[e] = 1'b1;
            checks++;
            if (req_ready !== onehot || n !== 0) begin
                failures++;
                $display("FAIL rr_grant op%0d: got ready=%b after %0d waits expected %b after 0", op, req_ready, n, onehot);
            end
            for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
            tick();
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 2'(e) || resp_data !== exp_data[e]) begin
                failures++;
                $display("FAIL rr_resp op%0d: got valid=%b id=%0d data=%0d expected 1/%0d/%0d",
                         op, resp_valid, resp_id, resp_data, e, exp_data[e]);
            end
            tick();
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt[i] !== 3) begin
                failures++;
                $display("FAIL rr_count req%0d: got %0d grants expected 3", i, cnt[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        set_req(1, 1'b1, 9'd200, 9'd100);
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 9'd100 || resp_id !== 2'd1 || req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold c%0d: got valid=%b data=%0d id=%0d ready=%b expected 1/100/1/0000",
                         c, resp_valid, resp_data, resp_id, req_ready);
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_before_handshake: got ready=%b valid=%b expected 0000/1", req_ready, resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_after_handshake: got valid=%b ready=%b expected 0/0100", resp_valid, req_ready);
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_reset_mid_op;
        logic [8:0] d;
        logic [1:0] id;
        bit         to;
        set_req(3, 1'b0, 9'd50, 9'd60);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid_grant: got %b expected 1000", req_ready);
        end
        tick();
        reset     = 1'b1;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_ready: got %b expected 0000", req_ready);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || dut.rr_ptr !== 2'd0 || alu_a !== 9'd0) begin
            failures++;
            $display("FAIL rst_mid_clear: got valid=%b rr_ptr=%0d alu_a=%0d expected 0/0/0", resp_valid, dut.rr_ptr, alu_a);
        end
        reset     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_resp: got valid=%b expected 0", resp_valid);
        end
        run_op(2, 1'b1, 9'd7, 9'd9, d, id, to);
        checks++;
        if (to || d !== 9'd510 || id !== 2'd2) begin
            failures++;
            $display("FAIL rst_mid_next: got data=%0d id=%0d timeout=%0d expected 510/2/0", d, id, to);
        end
    endtask

    task automatic test_sparse;
        logic [8:0] d;
        logic [1:0] id;
        bit         to;
        req_valid = '0;
        tick();
        tick();
        tick();
        checks++;
        if (dut.rr_ptr !== 2'd3) begin
            failures++;
            $display("FAIL idle_ptr_hold: got rr_ptr=%0d expected 3", dut.rr_ptr);
        end
        run_op(3, 1'b0, 9'd1, 9'd2, d, id, to);
        checks++;
        if (to || d !== 9'd3 || id !== 2'd3) begin
            failures++;
            $display("FAIL sparse_prev: got data=%0d id=%0d timeout=%0d expected 3/3/0", d, id, to);
        end
        set_req(2, 1'b0, 9'd300, 9'd300);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL sparse_grant: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (dut.rr_ptr !== 2'd3) begin
            failures++;
            $display("FAIL sparse_ptr: got rr_ptr=%0d expected 3", dut.rr_ptr);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 9'd88 || resp_id !== 2'd2) begin
            failures++;
            $display("FAIL sparse_resp: got valid=%b data=%0d id=%0d expected 1/88/2", resp_valid, resp_data, resp_id);
        end
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_select = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_op();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_sparse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
